// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: big-endian 32-bit word stream in, padded 16-word blocks out.
// Optional `SHA256_PAD_BLKCNT_EN adds a blk_cnt output counting completed blocks.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_blk_last,
  output logic        out_msg_last,
  output logic        busy,
  output logic        done
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PAD80, S_ZERO, S_LENHI, S_LENLO, S_DRAIN
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic             ov_q;
  logic [31:0]      od_q;
  logic [3:0]       oidx_q;
  logic             oblk_q;
  logic             omsg_q;

  logic        load_en;
  logic        take;
  logic        accept;
  logic [31:0] last_word;
  logic [5:0]  add_bits;
  logic [63:0] len64;

  assign load_en = !ov_q || out_ready;
  assign take    = ov_q && out_ready;
  assign in_ready = (state_q == S_DATA) && load_en;
  assign accept  = in_valid && in_ready;
  assign len64   = 64'(len_q);

  // Final-word formatting: keep valid bytes, marker in the next lane, zeros below.
  always_comb begin
    last_word = in_data;
    add_bits  = 6'd32;
    if (in_last) begin
      case (in_bytes)
        3'd0:    begin last_word = 32'h8000_0000;              add_bits = 6'd0;  end
        3'd1:    begin last_word = {in_data[31:24], 24'h800000}; add_bits = 6'd8;  end
        3'd2:    begin last_word = {in_data[31:16], 16'h8000};   add_bits = 6'd16; end
        3'd3:    begin last_word = {in_data[31:8], 8'h80};       add_bits = 6'd24; end
        default: begin last_word = in_data;                     add_bits = 6'd32; end
      endcase
    end
  end

  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_idx      = oidx_q;
  assign out_blk_last = oblk_q;
  assign out_msg_last = omsg_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DRAIN) && take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oidx_q  <= '0;
      oblk_q  <= 1'b0;
      omsg_q  <= 1'b0;
    end else begin
      if (take) ov_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            len_q   <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            ov_q   <= 1'b1;
            od_q   <= last_word;
            oidx_q <= idx_q;
            oblk_q <= (idx_q == 4'd15);
            omsg_q <= 1'b0;
            idx_q  <= idx_q + 4'd1;
            len_q  <= len_q + LEN_W'(add_bits);
            if (in_last) begin
              if (in_bytes >= 3'd4)      state_q <= S_PAD80;
              else if (idx_q == 4'd13)   state_q <= S_LENHI;
              else                       state_q <= S_ZERO;
            end
          end
        end
        S_PAD80, S_ZERO: begin
          if (load_en) begin
            ov_q   <= 1'b1;
            od_q   <= (state_q == S_PAD80) ? 32'h8000_0000 : 32'h0000_0000;
            oidx_q <= idx_q;
            oblk_q <= (idx_q == 4'd15);
            omsg_q <= 1'b0;
            idx_q  <= idx_q + 4'd1;
            // Marker/zero at 14 or 15 keeps filling through the wrap to the next 13.
            if (idx_q == 4'd13) state_q <= S_LENHI;
            else                state_q <= S_ZERO;
          end
        end
        S_LENHI: begin
          if (load_en) begin
            ov_q    <= 1'b1;
            od_q    <= len64[63:32];
            oidx_q  <= idx_q;
            oblk_q  <= 1'b0;
            omsg_q  <= 1'b0;
            idx_q   <= idx_q + 4'd1;
            state_q <= S_LENLO;
          end
        end
        S_LENLO: begin
          if (load_en) begin
            ov_q    <= 1'b1;
            od_q    <= len64[31:0];
            oidx_q  <= idx_q;
            oblk_q  <= 1'b1;
            omsg_q  <= 1'b1;
            idx_q   <= idx_q + 4'd1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (take) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] blk_cnt_q;
  assign blk_cnt = blk_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      blk_cnt_q <= '0;
    end else if (take && oblk_q) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding model plus per-cycle compare.
module tb_sha256_msg_padder;
  localparam int unsigned LEN_W = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [2:0]  in_bytes = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_blk_last;
  logic        out_msg_last;
  logic        busy;
  logic        done;
`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  sha256_msg_padder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_blk_last(out_blk_last), .out_msg_last(out_msg_last),
    .busy(busy), .done(done)
`ifdef SHA256_PAD_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] msg_q[$];
  logic [31:0] exp_q[$];
  int out_cnt = 0;
  int total_words = 0;
  bit bp_rand = 1'b0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_exp(input int lb);
    byte unsigned b[$];
    logic [63:0] bits;
    int nw;
    int eff;
    nw  = msg_q.size();
    eff = (lb > 4) ? 4 : lb;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      int nb;
      nb = (i == nw - 1) ? eff : 4;
      for (int j = 0; j < nb; j++) b.push_back(msg_q[i][31 - 8*j -: 8]);
    end
    bits = 64'(b.size()) * 64'd8;
    if (LEN_W < 64) bits = bits & ((64'd1 << LEN_W) - 64'd1);
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int j = 7; j >= 0; j--) b.push_back(bits[8*j +: 8]);
    for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endtask

  task automatic fill_seq(input int nw);
    msg_q.delete();
    for (int i = 0; i < nw; i++) msg_q.push_back(32'h0100_0000 + 32'(i));
  endtask

  task automatic fill_rand(input int nw);
    msg_q.delete();
    for (int i = 0; i < nw; i++) msg_q.push_back($urandom);
  endtask

  // Downstream ready: forced stall window, optional random throttling.
  always @(posedge clk) begin
    #2;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Per-cycle compare against the model queue.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_i;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {out_valid, out_idx, out_data}, {1'b1, prev_i, prev_d});
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          logic [31:0] w;
          w = exp_q.pop_front();
          check("out_data", out_data, w);
          check("out_idx", out_idx, out_cnt % 16);
          check("out_blk_last", out_blk_last, (out_cnt % 16) == 15);
          check("out_msg_last", out_msg_last, exp_q.size() == 0);
          check("done", done, exp_q.size() == 0);
          out_cnt++;
        end
      end else begin
        check("done_quiet", done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_i = out_idx;
    end
  end

  task automatic run_msg(input int lb, input bit bpr, input int stall_at);
    int nw;
    int budget;
    bit got;
    nw = msg_q.size();
    build_exp(lb);
    total_words = exp_q.size();
    out_cnt = 0;
    bp_rand = bpr;
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = msg_q[0];
    in_last = (nw == 1);
    in_bytes = (nw == 1) ? 3'(lb) : 3'($urandom_range(0, 7));
    @(negedge clk);
    check("in_ready_at_start", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 3'(lb) : 3'($urandom_range(0, 7));
      if (bpr && i < nw - 1 && $urandom_range(0, 7) == 0) start = 1'b1;
      if (i == stall_at) stall_cnt = 3;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 100) begin
        budget++;
        @(negedge clk);
      end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b0;
      if (bpr && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && done) got = 1'b1;
    end
    if (!got) check("done_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("model_drained", exp_q.size(), 0);
    check("word_count", out_cnt, total_words);
`ifdef SHA256_PAD_BLKCNT_EN
    check("blk_cnt", blk_cnt, total_words / 16);
`endif
    bp_rand = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {out_valid, in_ready, busy, done, out_blk_last, out_msg_last, out_idx, out_data}, '0);
    #2 reset_n = 1'b1;

    // Pin the model itself to hand-computed values.
    msg_q = '{32'h6162_6300};
    build_exp(3);
    check("model_abc_size", exp_q.size(), 16);
    check("model_abc_w0", exp_q[0], 32'h6162_6380);
    check("model_abc_w15", exp_q[15], 32'h0000_0018);
    fill_seq(14);
    build_exp(4);
    check("model_14w_size", exp_q.size(), 32);
    check("model_14w_w14", exp_q[14], 32'h8000_0000);
    check("model_14w_w31", exp_q[31], 32'h0000_01C0);
    fill_seq(20);
    build_exp(4);
    check("model_20w_w20", exp_q[20], 32'h8000_0000);
    check("model_20w_w31", exp_q[31], 32'h0000_0280);

    // Directed cases.
    msg_q = '{32'h6162_6300};
    run_msg(3, 1'b0, -1);
    msg_q = '{32'h0000_0000};
    run_msg(0, 1'b0, -1);
    fill_seq(14);
    run_msg(4, 1'b0, -1);
    fill_seq(20);
    run_msg(4, 1'b0, -1);
    fill_seq(13);
    run_msg(4, 1'b0, -1);
    fill_seq(14);
    run_msg(2, 1'b0, -1);
    fill_seq(15);
    run_msg(1, 1'b0, -1);
    fill_seq(20);
    run_msg(4, 1'b0, 6);

    // Reset while in zero fill aborts the message.
    msg_q = '{32'h6162_6300};
    build_exp(3);
    out_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h6162_6300;
    in_last = 1'b1;
    in_bytes = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int c = 0; c < 50 && out_cnt < 4; c++) @(negedge clk);
    check("reached_zero_fill", out_cnt >= 4, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs",
             {out_valid, in_ready, busy, done, out_blk_last, out_msg_last, out_idx, out_data}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    msg_q = '{32'h6162_6300};
    run_msg(3, 1'b0, -1);

    // Randomized messages under random backpressure.
    for (int t = 0; t < 25; t++) begin
      int nw;
      int lb;
      nw = $urandom_range(1, 40);
      lb = $urandom_range(0, 7);
      if (nw > 1 && lb == 0) lb = $urandom_range(1, 7);
      fill_rand(nw);
      run_msg(lb, 1'b1, ($urandom_range(0, 1) != 0) ? $urandom_range(0, nw - 1) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
